// File: rtl/mvm3_vec_accum.sv
// mvm3_vec_accum: sums NUM_VEC consecutive VEC_LEN-word signed vectors element-wise, then drains the sums.
// Define MVM_ACC_SAT_EN to clamp each accumulate to the signed ACC_W range instead of wrapping.
module mvm3_vec_accum #(
  parameter int IN_W    = 16,
  parameter int ACC_W   = 20,
  parameter int VEC_LEN = 3,
  parameter int NUM_VEC = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic             m_ready,
  input  logic [IN_W-1:0]  data_in,
  output logic             m_valid,
  output logic             s_ready,
  output logic [ACC_W-1:0] data_out
);

  // Handshakes: a word moves on any posedge where valid && ready; valid never waits on ready,
  // data is held while valid && !ready, and s_ready / m_valid are never high together.

  localparam int EW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [EW-1:0] ELEM_LAST = EW'(VEC_LEN - 1);
  localparam logic [VW-1:0] VEC_LAST  = VW'(NUM_VEC - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                  state;
  logic signed [ACC_W-1:0] acc [VEC_LEN];
  logic [EW-1:0]           elem;
  logic [EW-1:0]           out_idx;
  logic [VW-1:0]           vec;

  logic                    accept;
  logic                    take;
  logic signed [ACC_W-1:0] ext_in;
  logic signed [ACC_W-1:0] acc_cur;
  logic signed [ACC_W-1:0] add_raw;
  logic signed [ACC_W-1:0] add_res;

  assign accept  = s_valid && s_ready;
  assign take    = m_valid && m_ready;
  assign ext_in  = ACC_W'($signed(data_in));
  assign acc_cur = acc[elem];
  assign add_raw = acc_cur + ext_in;

`ifdef MVM_ACC_SAT_EN
  logic add_ovf;
  // Overflow only when both operands share a sign that the result lost.
  assign add_ovf = (acc_cur[ACC_W-1] == ext_in[ACC_W-1]) && (add_raw[ACC_W-1] != acc_cur[ACC_W-1]);
  always_comb begin
    add_res = add_raw;
    if (add_ovf) begin
      add_res = acc_cur[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign add_res = add_raw;
`endif

  assign data_out = m_valid ? acc[out_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACCUM;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      elem    <= '0;
      vec     <= '0;
      out_idx <= '0;
      for (int i = 0; i < VEC_LEN; i++) begin
        acc[i] <= '0;
      end
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            // First vector of a group loads so stale sums never leak into the next group.
            acc[elem] <= (vec == '0) ? ext_in : add_res;
            if (elem == ELEM_LAST) begin
              elem <= '0;
              if (vec == VEC_LAST) begin
                vec     <= '0;
                out_idx <= '0;
                state   <= DRAIN;
                s_ready <= 1'b0;
                m_valid <= 1'b1;
              end else begin
                vec <= vec + 1'b1;
              end
            end else begin
              elem <= elem + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (take) begin
            if (out_idx == ELEM_LAST) begin
              out_idx <= '0;
              state   <= ACCUM;
              m_valid <= 1'b0;
              s_ready <= 1'b1;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        default: begin
          state   <= ACCUM;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm3_vec_accum.sv
// Bench for mvm3_vec_accum: a 20-bit and a 17-bit instance share one stimulus stream; a queue scoreboard checks both.
module tb_mvm3_vec_accum;

  localparam int IN_W    = 16;
  localparam int VEC_LEN = 3;
  localparam int NUM_VEC = 5;
  localparam int GROUP   = VEC_LEN * NUM_VEC;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            s_valid = 1'b0;
  logic            m_ready = 1'b0;
  logic [IN_W-1:0] data_in = 'x;
  logic            m_valid_a, s_ready_a, m_valid_b, s_ready_b;
  logic [19:0]     data_out_a;
  logic [16:0]     data_out_b;

  mvm3_vec_accum #(.IN_W(IN_W), .ACC_W(20), .VEC_LEN(VEC_LEN), .NUM_VEC(NUM_VEC)) dut_a (
    .clk(clk), .reset(reset), .s_valid(s_valid), .m_ready(m_ready), .data_in(data_in),
    .m_valid(m_valid_a), .s_ready(s_ready_a), .data_out(data_out_a)
  );

  mvm3_vec_accum #(.IN_W(IN_W), .ACC_W(17), .VEC_LEN(VEC_LEN), .NUM_VEC(NUM_VEC)) dut_b (
    .clk(clk), .reset(reset), .s_valid(s_valid), .m_ready(m_ready), .data_in(data_in),
    .m_valid(m_valid_b), .s_ready(s_ready_b), .data_out(data_out_b)
  );

  // scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  int          words[$];
  logic [19:0] exp_a[$];
  logic [16:0] exp_b[$];
  bit          mon_en = 1'b0;
  bit          stall  = 1'b0;
  bit          bp_arm = 1'b0;
  int          bp_left = 0;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: each output is the element-wise sum over the group's vectors, reduced after every add.
  function automatic longint fit(input longint s, input int w);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
`ifdef MVM_ACC_SAT_EN
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    longint m = longint'(1) <<< w;
    s = s % m;
    if (s > hi) s -= m;
    if (s < lo) s += m;
    return s;
`endif
  endfunction

  task automatic model_push(input int w, output bit done);
    longint sa, sb;
    words.push_back(w);
    done = (words.size() == GROUP);
    if (done) begin
      for (int e = 0; e < VEC_LEN; e++) begin
        sa = words[e];
        sb = words[e];
        for (int v = 1; v < NUM_VEC; v++) begin
          sa = fit(sa + words[v*VEC_LEN + e], 20);
          sb = fit(sb + words[v*VEC_LEN + e], 17);
        end
        exp_a.push_back(20'(sa));
        exp_b.push_back(17'(sb));
      end
      words.delete();
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      data_in = 'x;
    end
  endtask

  task automatic send_word(input logic [IN_W-1:0] w, input bit gaps);
    int tries = 0;
    bit taken = 1'b0;
    bit done;
    while (!taken && tries < 200) begin
      @(negedge clk);
      tries++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        data_in = 'x;
      end else begin
        s_valid = 1'b1;
        data_in = w;
        if (s_ready_a === 1'b1) taken = 1'b1;
      end
    end
    if (!taken) begin
      chk("accept_timeout", 1'b0, tries, 0);
      s_valid = 1'b0;
      data_in = 'x;
      return;
    end
    model_push(int'($signed(w)), done);
    if (done) begin
      @(negedge clk);
      s_valid = 1'b0;
      data_in = 'x;
      chk("latency_m_valid", m_valid_a === 1'b1, 32'(m_valid_a), 1);
      if (exp_a.size() > 0)
        chk("latency_first_sum", data_out_a === exp_a[0], 32'(data_out_a), 32'(exp_a[0]));
    end
  endtask

  task automatic send_group(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                            input logic [IN_W-1:0] c, input bit gaps);
    for (int v = 0; v < NUM_VEC; v++) begin
      send_word(a, gaps);
      send_word(b, gaps);
      send_word(c, gaps);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_a.size() > 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_a.size() > 0) begin
      chk("drain_timeout", 1'b0, exp_a.size(), 0);
      exp_a.delete();
      exp_b.delete();
    end
    idle(2);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    s_valid = 1'b0;
    data_in = 'x;
    reset   = 1'b1;
    words.delete();
    exp_a.delete();
    exp_b.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_quiet(input int n, input string name);
    repeat (n) begin
      @(negedge clk);
      chk({name, "_m_valid"}, m_valid_a === 1'b0 && m_valid_b === 1'b0, 32'(m_valid_a), 0);
      chk({name, "_s_ready"}, s_ready_a === 1'b1, 32'(s_ready_a), 1);
    end
  endtask

  // monitor: drives m_ready and pops the scoreboard on every output handshake
  logic [19:0] ea;
  logic [16:0] eb;
  initial begin
    forever begin
      @(negedge clk);
      if (bp_arm && m_valid_a === 1'b1) begin
        bp_arm  = 1'b0;
        bp_left = 10;
      end
      if (bp_left > 0) begin
        m_ready = 1'b0;
        bp_left--;
        chk("bp_m_valid", m_valid_a === 1'b1, 32'(m_valid_a), 1);
        chk("bp_s_ready", s_ready_a === 1'b0, 32'(s_ready_a), 0);
        if (exp_a.size() > 0)
          chk("bp_hold_data", data_out_a === exp_a[0], 32'(data_out_a), 32'(exp_a[0]));
      end else if (stall) begin
        m_ready = 1'b0;
      end else begin
        m_ready = ($urandom_range(0, 3) != 0);
      end
      #1;
      if (mon_en && reset !== 1'b1) begin
        if (m_valid_a === 1'b1 && s_ready_a === 1'b1)
          chk("valid_ready_exclusive", 1'b0, 32'(s_ready_a), 0);
        if (m_valid_a === 1'b1 && m_ready) begin
          if (exp_a.size() == 0) begin
            chk("unexpected_output", 1'b0, 32'(data_out_a), 0);
          end else begin
            ea = exp_a.pop_front();
            eb = exp_b.pop_front();
            chk("sum_acc20", data_out_a === ea, 32'(data_out_a), 32'(ea));
            chk("sum_acc17", m_valid_b === 1'b1 && data_out_b === eb, 32'(data_out_b), 32'(eb));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  // test sequence and final report
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_m_valid", m_valid_a === 1'b0 && m_valid_b === 1'b0, 32'(m_valid_a), 0);
    chk("reset_data_out", data_out_a === 20'd0 && data_out_b === 17'd0, 32'(data_out_a), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_s_ready", s_ready_a === 1'b1 && s_ready_b === 1'b1, 32'(s_ready_a), 1);
    mon_en = 1'b1;

    // two identical groups: the second proves the first vector loads rather than adds
    send_group(16'd18, 16'd27, 16'd36, 1'b1);
    send_group(16'd18, 16'd27, 16'd36, 1'b1);
    wait_drain();

    // sign extension, and wrap/saturation in the 17-bit instance
    send_group(16'h8000, 16'h0001, 16'hFFFF, 1'b1);
    wait_drain();
    send_group(16'h7FFF, 16'h8000, 16'h0000, 1'b1);
    wait_drain();

    // downstream backpressure for 10 cycles once the sums appear
    bp_arm = 1'b1;
    send_group(16'd18, 16'd27, 16'd36, 1'b0);
    wait_drain();

    // reset after 7 accepted words: aborted group must produce nothing
    for (int i = 0; i < 7; i++) send_word(16'(i * 1000 + 5), 1'b1);
    pulse_reset();
    check_quiet(4, "midstream_reset");
    send_group(16'd18, 16'd27, 16'd36, 1'b1);
    wait_drain();

    // reset while outputs are pending in DRAIN
    stall = 1'b1;
    send_group(16'd100, 16'hFF00, 16'd7, 1'b0);
    pulse_reset();
    stall = 1'b0;
    check_quiet(4, "drain_reset");

    // random traffic with random gaps on both sides
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < GROUP; i++) send_word(16'($urandom_range(0, 65535)), 1'b1);
    end
    wait_drain();
    chk("partial_group_empty", words.size() == 0, words.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mvm3_vec_accum.md
Name: mvm3_vec_accum

Overview:
Downstream stage of mvm3_part1. Consumes its 16-bit signed y output stream, three words per result vector, over a valid/ready handshake. Accumulates NUM_VEC consecutive result vectors element by element into ACC_W-bit signed sums. Then emits the VEC_LEN sums on its own valid/ready output.

Parameters:
IN_W, 16, width of incoming signed y words (matches mvm3_part1 data_out)
ACC_W, 20, width of signed accumulators and data_out; must be >= IN_W
VEC_LEN, 3, elements per vector
NUM_VEC, 5, vectors summed per output group; must be >= 1

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
s_valid  input  1  upstream word valid (driven by mvm3_part1 m_valid)
m_ready  input  1  downstream ready
data_in  input  IN_W  signed y word (from mvm3_part1 data_out)
m_valid  output  1  output sum valid
s_ready  output  1  ready to accept data_in (drives mvm3_part1 m_ready)
data_out  output  ACC_W  signed accumulated sum

Behaviour:
- One clock, clk. Reset is synchronous and active-high; all state is updated on posedge clk.
- Storage: acc[0..VEC_LEN-1], each ACC_W bits signed; elem counter (0..VEC_LEN-1); vec counter (0..NUM_VEC-1); out_idx (0..VEC_LEN-1).
- FSM has two states:
  - ACCUM: s_ready=1, m_valid=0.
  - DRAIN: s_ready=0, m_valid=1.
- Reset: FSM goes to ACCUM. All counters and accumulators clear to 0. m_valid=0. data_out=0 while m_valid=0. s_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation (either state) discards partial sums and any pending outputs. No output is emitted for the aborted group.
- Accept occurs on (s_valid && s_ready) at posedge. data_in is sign-extended to ACC_W.
  - vec==0: acc[elem] <= ext(data_in) (load, not add).
  - vec>0: acc[elem] <= acc[elem] + ext(data_in).
- Counter advance on each accept:
  - elem increments; at VEC_LEN-1 it wraps to 0 and vec increments.
  - On the accept with elem==VEC_LEN-1 and vec==NUM_VEC-1: vec wraps to 0, out_idx <= 0, next state is DRAIN.
- data_in is ignored, and may be X, when s_valid=0 or s_ready=0. X must never propagate into acc.
- Latency: m_valid rises the cycle after the final word is accepted. data_out = acc[0] in that same cycle.
- DRAIN:
  - data_out = acc[out_idx], held stable while m_valid && !m_ready.
  - On (m_valid && m_ready): out_idx increments.
  - On the accept with out_idx==VEC_LEN-1: next state is ACCUM, m_valid=0 next cycle, s_ready=1 next cycle.
  - Upstream is stalled throughout DRAIN. No input is accepted in the same cycle as the last output handshake.
- Fully independent of upstream gaps and downstream backpressure. Throughput: one word per cycle in ACCUM, one per cycle in DRAIN.

Optional Feature:
Macro MVM_ACC_SAT_EN.
- Defined: each add saturates to the signed ACC_W range, [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Overflow is detected from operand signs vs result sign. Saturation is sticky only through the arithmetic, i.e. subsequent adds operate on the clamped value.
- Undefined: plain two's-complement wrap-around modulo 2^ACC_W.
- Either way, the load on vec==0 never saturates, since ACC_W >= IN_W.

Test Plan:
- Defaults. Five vectors of (18,27,36), random s_valid/m_ready gaps -> outputs 90,135,180 (0x0005A, 0x00087, 0x000B4). Then a second identical group -> the same three values, confirming the vec==0 load clears old sums.
- Defaults. Five vectors of (-32768, 1, -1) -> -163840 (0xD8000), 5, -5 (0xFFFFB). Sign extension is correct.
- ACC_W=17. Five vectors of (32767, -32768, 0):
  - MVM_ACC_SAT_EN defined -> 65535, -65536, 0.
  - Macro undefined -> 32763, -32768 (wrap of -163840 mod 2^17 = -32768), 0.
- Backpressure. Hold m_ready=0 for 10 cycles after m_valid rises -> data_out stays 90, m_valid stays 1, s_ready stays 0. Then release -> 90,135,180 in order.
- Reset mid-stream. Assert reset for 1 cycle after 7 accepted words -> no m_valid. Then a clean group of five (18,27,36) vectors -> 90,135,180 exactly.
- Drive data_in=X with s_valid=0 on random cycles throughout, and hold s_valid=1 with X-free data during DRAIN -> no X ever appears on data_out while m_valid=1. The words offered during DRAIN are accepted only after returning to ACCUM.
